// File: rtl/fifo_pkg.sv
// Shared FIFO defaults and the pointer-width helper used for port and register sizing.
package fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 256;

  // Smallest r with 2**r >= n; usable in parameter and port width expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage, WIDTH x DEPTH, one write and one read port, no reset.
// Read data is registered and holds between enabled reads; same-address read/write returns the old word.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    rd_en,
  input  logic [clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]        rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with 1-cycle registered read, occupancy flags and sticky over/underflow errors.
// Rejected writes (full, no read) and reads (empty) set the error flags and leave storage untouched.
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AFULL_TH  = DEPTH - 4,
  parameter int AEMPTY_TH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [WIDTH-1:0]      dataIn,
  input  logic                  write,
  input  logic                  read,
  input  logic                  clearErr,
  output logic [WIDTH-1:0]      dataOut,
  output logic                  full,
  output logic                  empty,
  output logic                  almostFull,
  output logic                  almostEmpty,
  output logic [clog2(DEPTH):0] count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_LIM = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LIM   = CW'(AFULL_TH);
  localparam logic [CW-1:0] AE_LIM   = CW'(AEMPTY_TH);

  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    cnt;
  logic             rd_seen;
  logic             rd_acc;
  logic             wr_acc;
  logic [WIDTH-1:0] ram_q;

  // A read frees a slot in the same edge, so a full FIFO still accepts a paired write.
  assign rd_acc = !RST && read && (cnt != '0);
  assign wr_acc = !RST && write && ((cnt != FULL_LIM) || rd_acc);

  fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk     (CLK),
    .wr_en   (wr_acc),
    .wr_addr (wptr),
    .wr_data (dataIn),
    .rd_en   (rd_acc),
    .rd_addr (rptr),
    .rd_data (ram_q)
  );

  // The RAM register is not reset, so dataOut reads as zero until the first accepted read.
  assign dataOut     = rd_seen ? ram_q : '0;
  assign count       = cnt;
  assign full        = (cnt == FULL_LIM);
  assign empty       = (cnt == '0);
  assign almostFull  = (cnt >= AF_LIM);
  assign almostEmpty = (cnt <= AE_LIM);

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr      <= '0;
      rptr      <= '0;
      cnt       <= '0;
      rd_seen   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) begin
        rptr    <= rptr + 1'b1;
        rd_seen <= 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      overflow  <= (overflow && !clearErr) || (write && !wr_acc);
      underflow <= (underflow && !clearErr) || (read && !rd_acc);
    end
  end

endmodule

// File: doc/fifo_sync.md
FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 256, number of entries (power of two, >=4).
REQ-003 SHALL have parameter AFULL_TH, default DEPTH-4, occupancy at or above which almostFull asserts.
REQ-004 SHALL have parameter AEMPTY_TH, default 4, occupancy at or below which almostEmpty asserts.
REQ-005 SHALL have port CLK  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port dataIn  input  WIDTH  write data.
REQ-008 SHALL have port write  input  1  write request.
REQ-009 SHALL have port read  input  1  read request.
REQ-010 SHALL have port clearErr  input  1  clears sticky error flags.
REQ-011 SHALL have port dataOut  output  WIDTH  registered read data.
REQ-012 SHALL have ports full, empty, almostFull, almostEmpty  output  1 each  status flags.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-015 SHALL accept a read when read=1 and count>0; on acceptance, dataOut takes the oldest entry at that same edge (1-cycle latency), and read pointer increments.
REQ-016 SHALL hold dataOut unchanged in any cycle without an accepted read.
REQ-017 SHALL accept a write when write=1 and (count<DEPTH or a read is accepted in the same cycle); on acceptance, dataIn is stored at the write pointer and the write pointer increments.
REQ-018 SHALL, on write with read while empty, accept the write only; the read is rejected and dataOut holds.
REQ-019 SHALL, on write with read while full, accept both; count stays DEPTH; dataOut gets the oldest entry, never the incoming word.
REQ-020 SHALL keep pointers $clog2(DEPTH) bits wide, wrapping modulo DEPTH; count +1 on write-only, -1 on read-only, unchanged otherwise.
REQ-021 SHALL derive full=(count==DEPTH), empty=(count==0), almostFull=(count>=AFULL_TH), almostEmpty=(count<=AEMPTY_TH), all combinational from the count register.
REQ-022 SHALL set overflow at the edge where write=1 is rejected; set underflow at the edge where read=1 is rejected; both remain set until cleared.
REQ-023 SHALL clear overflow/underflow at the edge where clearErr=1, except that a new error event in the same cycle wins (flag remains/becomes 1).
REQ-024 SHALL leave memory contents and dataOut unaffected by rejected operations.

Reset
REQ-025 SHALL, at an edge with RST=1, set pointers=0, count=0, dataOut=0, overflow=0, underflow=0, ignoring write, read and clearErr in that cycle.
REQ-026 SHALL present empty=1, almostEmpty=1, full=0, almostFull=0 (for AFULL_TH>0) after reset; memory array not reset.
REQ-027 SHALL discard all stored data on RST asserted mid-operation; first post-reset write is next word read.

Structure
REQ-028 SHALL place default WIDTH/DEPTH constants and a pointer-width helper (clog2) in shared package fifo_pkg.
REQ-029 SHALL implement storage as sub-module fifo_ram: simple dual-port, one synchronous write port, one synchronous read port, WIDTH x DEPTH, no reset.
REQ-030 SHALL keep pointer, count, flag and error logic in fifo_sync.

Verification (WIDTH=8, DEPTH=16, AFULL_TH=12, AEMPTY_TH=4)
REQ-031 SHALL check: reset, write 0x01..0x10 -> full=1 after 16th, count=16; read 16 -> dataOut 0x01..0x10 in order, each 1 cycle after read, empty=1.
REQ-032 SHALL check: when full, write 0xAA alone -> overflow=1, count=16, 0xAA never read; clearErr pulse -> overflow=0.
REQ-033 SHALL check: when empty, read and write 0x55 together -> underflow=1, count=1, next read returns 0x55.
REQ-034 SHALL check: when full, simultaneous read+write of 0x77 for 40 cycles -> count stays 16, no overflow, data order preserved across pointer wrap.
REQ-035 SHALL check: count 4->5 -> almostEmpty 1->0; count 11->12 -> almostFull 0->1.
REQ-036 SHALL check: RST asserted at count=9 with write=1 -> count=0, empty=1, dataOut=0, written word discarded.
